bit_serializer: RTL and testbench

- Upstream feeder for the serial pattern-detector FSM. Accepts a parallel word over a valid/ready handshake and shifts it out one bit per enabled cycle on a single-bit line. That line drives the detector's serial `in` input.
- Provides frame markers (`ser_valid`, `ser_last`) so benches and coverage can align detector output pulses to word boundaries.

---
 rtl/bit_serializer_if.sv | 19 +
 rtl/bit_serializer.sv | 133 +++++++++++++
 tb/tb_bit_serializer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
//   Parallel-word valid/ready handshake feeding bit_serializer.
//   Members:
//     in_data  [WIDTH] word to serialize      (source -> serializer)
//     in_valid         in_data is valid       (source -> serializer)
//     in_ready         serializer can take it (serializer -> source)
//   Modports: master = word source, slave = serializer.
// ---------------------------------------------------------------------------
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
//   Takes a parallel word over a valid/ready handshake and shifts it out one
//   bit per bit_en strobe on a single serial line (the pattern detector's
//   serial input), with frame markers for word alignment.
//
//   Parameters:
//     WIDTH     bits per word (2..32)
//     MSB_FIRST 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//     IDLE_BIT  level driven on o_ser_bit between words
//
//   Ports:
//     i_clk       clock, rising edge
//     i_rst_n     asynchronous reset, active low
//     i_bit_en    bit-rate strobe; a bit advances only on strobed edges
//     s_in        handshake (in_data / in_valid / in_ready), slave side
//     o_ser_bit   serial data
//     o_ser_valid o_ser_bit carries a word bit
//     o_ser_last  current bit is the last of the word
//     o_busy      a word is loaded and not fully sent
//
//   Build option:
//     BIT_SERIALIZER_BACK2BACK_EN  when defined, a new word may be taken on
//     the strobed edge that retires the last bit, so consecutive words leave
//     with no idle slot between them.
// ---------------------------------------------------------------------------
module bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_bit_en,
  bit_serializer_if.slave  s_in,
  output logic             o_ser_bit,
  output logic             o_ser_valid,
  output logic             o_ser_last,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt,   w_cnt_nxt;

  logic             w_last;
  logic             w_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_shift_adv;
  logic             w_out_end;

  // Counter holds the number of bits still to follow the current one.
  assign w_last = (r_cnt == '0);

`ifdef BIT_SERIALIZER_BACK2BACK_EN
  // The strobed edge that retires the last bit can also load the next word.
  assign w_ready = (r_state == ST_IDLE) ||
                   ((r_state == ST_SHIFT) && w_last && i_bit_en);
`else
  assign w_ready = (r_state == ST_IDLE);
`endif

  assign w_xfer        = s_in.in_valid && w_ready;
  assign s_in.in_ready = w_ready;

  // Output end of the register and the shift that moves the next bit there.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_out_end   = r_shift[WIDTH-1];
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign w_out_end   = r_shift[0];
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_shift_nxt = s_in.in_data;
          w_cnt_nxt   = CW'(WIDTH - 1);
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Without a strobe everything holds, stretching the current bit.
        if (i_bit_en) begin
          if (!w_last) begin
            w_shift_nxt = w_shift_adv;
            w_cnt_nxt   = r_cnt - 1'b1;
          end else if (w_xfer) begin
            // Only reachable with back-to-back loading enabled.
            w_shift_nxt = s_in.in_data;
            w_cnt_nxt   = CW'(WIDTH - 1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // All serial outputs come from registers only.
  assign o_ser_valid = (r_state == ST_SHIFT);
  assign o_busy      = (r_state == ST_SHIFT);
  assign o_ser_bit   = (r_state == ST_SHIFT) ? w_out_end : IDLE_BIT;
  assign o_ser_last  = (r_state == ST_SHIFT) && w_last;

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  localparam int   W        = 8;
  localparam logic IDLE_BIT = 1'b0;
`ifdef BIT_SERIALIZER_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  // {in_ready, ser_bit, ser_valid, ser_last, busy}
  localparam logic [4:0] RST_V = {1'b1, IDLE_BIT, 3'b000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic drv_be = 1'b1;
  logic drv_valid = 1'b0;
  logic [W-1:0] drv_data = '0;

  always #5 clk = ~clk;

  bit_serializer_if #(.WIDTH(W)) ifa ();
  bit_serializer_if #(.WIDTH(W)) ifb ();
  assign ifa.in_valid = drv_valid;
  assign ifa.in_data  = drv_data;
  assign ifb.in_valid = drv_valid;
  assign ifb.in_data  = drv_data;

  logic a_bit, a_vld, a_last, a_busy;
  logic b_bit, b_vld, b_last, b_busy;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_BIT(IDLE_BIT)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(drv_be), .s_in(ifa),
    .o_ser_bit(a_bit), .o_ser_valid(a_vld), .o_ser_last(a_last), .o_busy(a_busy));

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_BIT(IDLE_BIT)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(drv_be), .s_in(ifb),
    .o_ser_bit(b_bit), .o_ser_valid(b_vld), .o_ser_last(b_last), .o_busy(b_busy));

  wire [4:0] obs_a = {ifa.in_ready, a_bit, a_vld, a_last, a_busy};
  wire [4:0] obs_b = {ifb.in_ready, b_bit, b_vld, b_last, b_busy};

  // Reference model: the line is a queue of bits still to be shown; the
  // head is what is on the wire right now.
  bit qa[$];
  bit qb[$];
  logic m_acc = 1'b0;

  function automatic logic exp_rdy();
    return (qa.size() == 0) || (B2B && qa.size() == 1 && drv_be);
  endfunction

  function automatic logic [4:0] exp_a();
    int n = qa.size();
    return {exp_rdy(), (n != 0) ? logic'(qa[0]) : IDLE_BIT, n != 0, n == 1, n != 0};
  endfunction

  function automatic logic [4:0] exp_b();
    int n = qb.size();
    return {exp_rdy(), (n != 0) ? logic'(qb[0]) : IDLE_BIT, n != 0, n == 1, n != 0};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete();
      qb.delete();
      m_acc <= 1'b0;
    end else if (drv_valid && exp_rdy()) begin
      if (qa.size() != 0) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      for (int i = 0; i < W; i++) begin
        qa.push_back(drv_data[W-1-i]);
        qb.push_back(drv_data[i]);
      end
      m_acc <= 1'b1;
    end else begin
      m_acc <= 1'b0;
      if (qa.size() != 0 && drv_be) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drv_valid = 1'b0;
    drv_be = 1'b1;
    #3;
    n_cmp++;
    if ({obs_a, obs_b} !== {RST_V, RST_V}) begin
      n_bad++;
      $display("FAIL reset_state got=%b/%b exp=%b", obs_a, obs_b, RST_V);
    end
    drv_valid = 1'b1;
    drv_data = W'($urandom);
    tick();
    n_cmp++;
    if ({obs_a, obs_b} !== {RST_V, RST_V}) begin
      n_bad++;
      $display("FAIL reset_no_capture got=%b/%b exp=%b", obs_a, obs_b, RST_V);
    end
    drv_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({obs_a, obs_b} !== {RST_V, RST_V}) begin
      n_bad++;
      $display("FAIL reset_release got=%b/%b exp=%b", obs_a, obs_b, RST_V);
    end
  endtask

  // One word, bit_en strobed every 'per' cycles.
  task automatic test_word(input logic [W-1:0] w, input int per, input string nm);
    logic [W-1:0] sa = '0, sb = '0, rev;
    int nv = 0;
    for (int i = 0; i < W; i++) rev[i] = w[W-1-i];
    drv_data = w;
    drv_valid = 1'b1;
    drv_be = 1'b1;
    tick();
    n_cmp++;
    if (m_acc !== 1'b1 || {obs_a, obs_b} !== {exp_a(), exp_b()}) begin
      n_bad++;
      $display("FAIL %s_accept acc=%b got=%b/%b exp=%b/%b", nm, m_acc, obs_a, obs_b, exp_a(), exp_b());
    end
    drv_valid = 1'b0;
    for (int e = 1; e <= W * per + 2; e++) begin
      if (a_vld) nv++;
      drv_be = (e % per == 0);
      if (a_vld && drv_be) begin
        sa = {sa[W-2:0], a_bit};
        sb = {sb[W-2:0], b_bit};
      end
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_bad++;
        $display("FAIL %s_cyc%0d got=%b/%b exp=%b/%b", nm, e, obs_a, obs_b, exp_a(), exp_b());
      end
    end
    drv_be = 1'b1;
    n_cmp++;
    if (sa !== w || sb !== rev) begin
      n_bad++;
      $display("FAIL %s_order got=%h/%h exp=%h/%h", nm, sa, sb, w, rev);
    end
    n_cmp++;
    if (nv != W * per) begin
      n_bad++;
      $display("FAIL %s_valid_cycles got=%0d exp=%0d", nm, nv, W * per);
    end
  endtask

  // Valid held during SHIFT; checks the inter-word gap and 1-0-1 runs on
  // the MSB-first line (what the detector would see).
  task automatic test_back_to_back();
    bit line[$];
    int k = 0, gap = 0, hits = 0;
    bit done = 1'b0;
    drv_data = 8'h05;
    drv_valid = 1'b1;
    drv_be = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_bad++;
        $display("FAIL b2b_cyc%0d got=%b/%b exp=%b/%b", c, obs_a, obs_b, exp_a(), exp_b());
      end
      if (m_acc) begin
        k++;
        if (k == 1) drv_data = 8'h40;
        else drv_valid = 1'b0;
      end
      if (k == 2 && qa.size() == 0) done = 1'b1;
      else if (k >= 1) begin
        line.push_back(a_bit);
        if (!a_vld) gap++;
      end
    end
    drv_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL b2b_timeout words=%0d exp=2", k);
    end
    n_cmp++;
    if (gap != (B2B ? 0 : 1)) begin
      n_bad++;
      $display("FAIL b2b_gap got=%0d exp=%0d", gap, B2B ? 0 : 1);
    end
    for (int i = 0; i + 2 < line.size(); i++)
      if (line[i] && !line[i+1] && line[i+2]) hits++;
    n_cmp++;
    if (hits != (B2B ? 2 : 1)) begin
      n_bad++;
      $display("FAIL b2b_101_runs got=%0d exp=%0d", hits, B2B ? 2 : 1);
    end
  endtask

  task automatic test_reset_mid();
    drv_data = 8'hFF;
    drv_valid = 1'b1;
    drv_be = 1'b1;
    tick();
    drv_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    n_cmp++;
    if (a_vld !== 1'b1 || a_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_pre vld=%b busy=%b exp=1/1", a_vld, a_busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({obs_a, obs_b} !== {RST_V, RST_V}) begin
      n_bad++;
      $display("FAIL midrst_immediate got=%b/%b exp=%b", obs_a, obs_b, RST_V);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({obs_a, obs_b} !== {RST_V, RST_V}) begin
      n_bad++;
      $display("FAIL midrst_no_resume got=%b/%b exp=%b", obs_a, obs_b, RST_V);
    end
    test_word(8'h0F, 1, "after_rst");
  endtask

  task automatic test_random();
    drv_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      drv_be = ($urandom_range(0, 3) != 0);
      tick();
      n_cmp++;
      if ({obs_a, obs_b} !== {exp_a(), exp_b()}) begin
        n_bad++;
        $display("FAIL rand_cyc%0d got=%b/%b exp=%b/%b", c, obs_a, obs_b, exp_a(), exp_b());
      end
      if (m_acc) drv_valid = 1'b0;
      if (!drv_valid) begin
        drv_valid = ($urandom_range(0, 2) == 0);
        drv_data = W'($urandom);
      end
    end
    drv_valid = 1'b0;
    drv_be = 1'b1;
    for (int c = 0; c < W + 2; c++) tick();
    n_cmp++;
    if ({obs_a, obs_b} !== {RST_V, RST_V}) begin
      n_bad++;
      $display("FAIL rand_drain got=%b/%b exp=%b", obs_a, obs_b, RST_V);
    end
  endtask

  initial begin
    test_reset();
    test_word(8'hA5, 1, "a5");
    test_word(8'h01, 1, "w01");
    test_word(8'hF0, 3, "stretch_f0");
    test_word(W'($urandom), 2, "rand_word");
    test_back_to_back();
    tick();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
